// File: rtl/bicubic_pkg.sv
// Shared FSM state encoding and AXI constants for the AXI-Stream to AXI4 burst writer.
package bicubic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_DONE
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic logic [2:0] axi_size(input int dw);
    return 3'($clog2(dw / 8));
  endfunction

endpackage

// File: rtl/axis_burst_writer_if.sv
// Stream-in / AXI4 write-out bundle seen from the writer (master) and the environment (slave).
interface axis_burst_writer_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic [DW-1:0]   tdata;
  logic            tvalid;
  logic            tready;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  // Every channel transfers on the rising edge where valid and ready are both high;
  // a source holds valid and payload stable until that edge.
  modport master (
    input  tdata, tvalid, awready, wready, bresp, bvalid,
    output tready, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready
  );

  modport slave (
    output tdata, tvalid, awready, wready, bresp, bvalid,
    input  tready, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            din,
  output logic                     full,
  input  logic                     pop,
  output logic [DW-1:0]            dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Push is refused when full and pop when empty, so a simultaneous request at either limit loses nothing.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (PW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/axis_burst_writer.sv
// Buffers an AXI-Stream and writes it to memory as a sequence of AXI4 INCR bursts, one at a time.
module axis_burst_writer
  import bicubic_pkg::*;
#(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int IRQ_CYCLES = 3
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic            start,
  input  logic [AW-1:0]   dst_addr,
  input  logic [31:0]     total_beats,
  input  logic [DW-1:0]   s_axis_tdata,
  input  logic            s_axis_tvalid,
  output logic            s_axis_tready,
  output logic [AW-1:0]   m_axi_awaddr,
  output logic [7:0]      m_axi_awlen,
  output logic            m_axi_awvalid,
  output logic [2:0]      m_axi_awsize,
  output logic [1:0]      m_axi_awburst,
  input  logic            m_axi_awready,
  output logic [DW-1:0]   m_axi_wdata,
  output logic [DW/8-1:0] m_axi_wstrb,
  output logic            m_axi_wlast,
  output logic            m_axi_wvalid,
  input  logic            m_axi_wready,
  input  logic [1:0]      m_axi_bresp,
  input  logic            m_axi_bvalid,
  output logic            m_axi_bready,
  output logic            busy,
  output logic            err,
  output logic            finish_irq
);
  localparam int BYTES = DW / 8;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  state_t          state;
  logic [AW-1:0]   base_addr;
  logic [31:0]     issued;
  logic [31:0]     remaining;
  logic [31:0]     irq_cnt;
  logic [8:0]      beats;
  logic [8:0]      beat_idx;
  logic [8:0]      next_beats;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_pop;
  logic [DW-1:0]   fifo_dout;
  logic [CW-1:0]   fifo_count;

  assign s_axis_tready = !fifo_full;
  assign fifo_pop      = m_axi_wvalid && m_axi_wready;
  assign m_axi_wdata   = (m_axi_wvalid && !fifo_empty) ? fifo_dout : '0;
  assign m_axi_wstrb   = '1;
  assign m_axi_awsize  = axi_size(DW);
  assign m_axi_awburst = AXI_BURST_INCR;

  sync_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (aclk),
    .rst   (areset),
    .push  (s_axis_tvalid),
    .din   (s_axis_tdata),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    next_beats = 9'(BURST_LEN);
    if (remaining < 32'(BURST_LEN)) next_beats = remaining[8:0];
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= ST_IDLE;
      base_addr     <= '0;
      issued        <= '0;
      remaining     <= '0;
      irq_cnt       <= '0;
      beats         <= '0;
      beat_idx      <= '0;
      m_axi_awaddr  <= '0;
      m_axi_awlen   <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wlast   <= 1'b0;
      m_axi_bready  <= 1'b0;
      busy          <= 1'b0;
      err           <= 1'b0;
      finish_irq    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            base_addr <= dst_addr;
            remaining <= total_beats;
            issued    <= '0;
            err       <= 1'b0;
            busy      <= 1'b1;
            if (total_beats == '0) begin
              state      <= ST_DONE;
              finish_irq <= 1'b1;
              irq_cnt    <= '0;
            end else begin
              state <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          // The whole burst is already buffered before AW goes out, so W never stalls mid-burst.
          if (!m_axi_awvalid) begin
            if (32'(fifo_count) >= 32'(next_beats)) begin
              m_axi_awvalid <= 1'b1;
              m_axi_awaddr  <= base_addr + AW'(issued) * AW'(BYTES);
              m_axi_awlen   <= 8'(next_beats - 9'd1);
              beats         <= next_beats;
            end
          end else if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b1;
            m_axi_wlast   <= (beats == 9'd1);
            beat_idx      <= '0;
            state         <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (m_axi_wready) begin
            if (m_axi_wlast) begin
              m_axi_wvalid <= 1'b0;
              m_axi_wlast  <= 1'b0;
              m_axi_bready <= 1'b1;
              issued       <= issued + 32'(beats);
              remaining    <= remaining - 32'(beats);
              state        <= ST_RESP;
            end else begin
              beat_idx    <= beat_idx + 9'd1;
              m_axi_wlast <= (beat_idx + 9'd2 == beats);
            end
          end
        end
        ST_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            if (m_axi_bresp != AXI_RESP_OKAY) err <= 1'b1;
            if (remaining != '0) begin
              state <= ST_ADDR;
            end else begin
              state      <= ST_DONE;
              finish_irq <= 1'b1;
              irq_cnt    <= '0;
            end
          end
        end
        ST_DONE: begin
          if (irq_cnt == 32'(IRQ_CYCLES - 1)) begin
            finish_irq <= 1'b0;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            irq_cnt <= irq_cnt + 32'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_burst_writer.sv
// Directed job sequence with random stream/ready timing; AW and W traffic checked against expected queues.
module tb_axis_burst_writer;
  localparam int DW = 32, AW = 32, BURST_LEN = 16, FIFO_DEPTH = 64, IRQ_CYCLES = 3;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] dst_addr = '0;
  logic [31:0]   total_beats = '0;
  logic          busy, err, finish_irq;

  axis_burst_writer_if #(.DW(DW), .AW(AW)) bus ();

  axis_burst_writer #(
    .DW(DW), .AW(AW), .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH), .IRQ_CYCLES(IRQ_CYCLES)
  ) dut (
    .aclk(aclk), .areset(areset), .start(start), .dst_addr(dst_addr), .total_beats(total_beats),
    .s_axis_tdata(bus.tdata), .s_axis_tvalid(bus.tvalid), .s_axis_tready(bus.tready),
    .m_axi_awaddr(bus.awaddr), .m_axi_awlen(bus.awlen), .m_axi_awvalid(bus.awvalid),
    .m_axi_awsize(bus.awsize), .m_axi_awburst(bus.awburst), .m_axi_awready(bus.awready),
    .m_axi_wdata(bus.wdata), .m_axi_wstrb(bus.wstrb), .m_axi_wlast(bus.wlast),
    .m_axi_wvalid(bus.wvalid), .m_axi_wready(bus.wready),
    .m_axi_bresp(bus.bresp), .m_axi_bvalid(bus.bvalid), .m_axi_bready(bus.bready),
    .busy(busy), .err(err), .finish_irq(finish_irq)
  );

  // clock / watchdog
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int             n_cmp = 0;
  int             n_fail = 0;
  logic [DW-1:0]  exp_q[$];
  logic [AW+7:0]  aw_exp[$];
  logic [1:0]     b_plan[$];
  int             words_to_send = 0;
  int             stream_pct = 50;
  int             rdy_pct = 50;
  bit             stream_en = 1'b1;
  bit             rdy_en = 1'b1;
  bit             mon_hold = 1'b0;
  bit             s_acc = 1'b0;
  bit             b_acc = 1'b0;
  int             pending_b = 0;
  int             aw_count = 0;
  bit             aw_open = 1'b0;
  bit             aw_pend = 1'b0;
  logic [AW+7:0]  aw_hold = '0;
  bit             in_burst = 1'b0;
  int             beat_cnt = 0;
  logic [7:0]     cur_len = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // monitor: samples on the falling edge, i.e. the values the next rising edge will use
  always @(negedge aclk) begin
    logic [AW+7:0] e;
    s_acc = bus.tvalid && bus.tready && !areset;
    b_acc = bus.bvalid && bus.bready && !areset;
    if (s_acc) exp_q.push_back(bus.tdata);
    if (!areset && !mon_hold) begin
      if (aw_pend) check("aw_stable", {1'b1, bus.awaddr, bus.awlen}, {1'b1, aw_hold}) ;
      if (aw_pend) check("aw_valid_held", bus.awvalid, 1'b1);
      aw_pend = bus.awvalid && !bus.awready;
      aw_hold = {bus.awaddr, bus.awlen};
      if (bus.awvalid && bus.awready) begin
        check("aw_single_outstanding", aw_open, 1'b0);
        if (aw_exp.size() == 0) begin
          check("aw_unexpected", 1'b1, 1'b0);
        end else begin
          e = aw_exp.pop_front();
          check("awaddr", bus.awaddr, e[AW+7:8]);
          check("awlen", bus.awlen, e[7:0]);
        end
        aw_open  = 1'b1;
        cur_len  = bus.awlen;
        beat_cnt = 0;
        aw_count++;
      end
      if (in_burst) check("wvalid_hold", bus.wvalid, 1'b1);
      if (bus.wvalid && bus.wready) begin
        check("w_after_aw", aw_open, 1'b1);
        if (exp_q.size() == 0) check("w_unexpected", 1'b1, 1'b0);
        else check("wdata", bus.wdata, exp_q.pop_front());
        check("wlast", bus.wlast, (beat_cnt == int'(cur_len)));
        if (bus.wlast) begin
          in_burst = 1'b0;
          pending_b++;
        end else begin
          in_burst = 1'b1;
          beat_cnt++;
        end
      end
      if (bus.bvalid && bus.bready) aw_open = 1'b0;
    end
  end

  // stream driver
  initial begin
    bus.tvalid = 1'b0;
    bus.tdata  = '0;
    forever begin
      @(posedge aclk);
      #1;
      if (!stream_en) begin
        bus.tvalid = 1'b0;
      end else if (!bus.tvalid || s_acc) begin
        if (words_to_send > 0 && $urandom_range(99) < stream_pct) begin
          bus.tvalid = 1'b1;
          bus.tdata  = DW'($urandom);
          words_to_send--;
        end else begin
          bus.tvalid = 1'b0;
        end
      end
    end
  end

  // AW / W ready driver
  initial begin
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      bus.awready = rdy_en && ($urandom_range(99) < rdy_pct);
      bus.wready  = rdy_en && ($urandom_range(99) < rdy_pct);
    end
  end

  // B response driver
  initial begin
    bus.bvalid = 1'b0;
    bus.bresp  = 2'b00;
    forever begin
      @(posedge aclk);
      #1;
      if (!rdy_en) begin
        bus.bvalid = 1'b0;
      end else if (!bus.bvalid || b_acc) begin
        bus.bvalid = 1'b0;
        if (pending_b > 0 && $urandom_range(99) < rdy_pct) begin
          bus.bvalid = 1'b1;
          bus.bresp  = (b_plan.size() > 0) ? b_plan.pop_front() : 2'b00;
          pending_b--;
        end
      end
    end
  end

  task automatic plan_job(input logic [AW-1:0] addr, input int beats);
    int rem = beats;
    int iss = 0;
    int len;
    while (rem > 0) begin
      len = (rem > BURST_LEN) ? BURST_LEN : rem;
      aw_exp.push_back({addr + AW'(iss * (DW / 8)), 8'(len - 1)});
      iss += len;
      rem -= len;
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] addr, input int beats);
    @(negedge aclk);
    start       = 1'b1;
    dst_addr    = addr;
    total_beats = 32'(beats);
    @(negedge aclk);
    start = 1'b0;
  endtask

  task automatic wait_done(input logic exp_err);
    int t = 0;
    int hi = 0;
    while (!finish_irq && t < 3000) begin
      @(negedge aclk);
      t++;
    end
    check("irq_seen", finish_irq, 1'b1);
    check("busy_in_done", busy, 1'b1);
    while (finish_irq && hi < 10) begin
      hi++;
      @(negedge aclk);
    end
    check("irq_len", 64'(hi), 64'(IRQ_CYCLES));
    check("busy_after_done", busy, 1'b0);
    check("err_at_end", err, exp_err);
    check("aw_all_issued", 64'(aw_exp.size()), 64'd0);
    check("data_all_written", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int aw_base;
    int t;

    // reset values
    repeat (3) @(negedge aclk);
    check("rst_awvalid", bus.awvalid, 1'b0);
    check("rst_wvalid", bus.wvalid, 1'b0);
    check("rst_bready", bus.bready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_irq", finish_irq, 1'b0);
    check("rst_awaddr", bus.awaddr, '0);
    check("rst_awlen", bus.awlen, '0);
    check("rst_wdata", bus.wdata, '0);
    areset = 1'b0;
    @(negedge aclk);
    check("tready_empty", bus.tready, 1'b1);
    check("awsize", bus.awsize, 3'd2);
    check("awburst", bus.awburst, 2'b01);
    check("wstrb", bus.wstrb, 4'hf);

    // 40 beats at 0xE0000000: bursts of 16, 16, 8
    aw_base = aw_count;
    plan_job(32'hE000_0000, 40);
    words_to_send += 40;
    pulse_start(32'hE000_0000, 40);
    check("busy_after_start", busy, 1'b1);
    wait_done(1'b0);
    check("job40_bursts", 64'(aw_count - aw_base), 64'd3);

    // SLVERR on the second of three bursts
    aw_base = aw_count;
    b_plan.push_back(2'b00);
    b_plan.push_back(2'b10);
    b_plan.push_back(2'b00);
    plan_job(32'h0000_1000, 40);
    words_to_send += 40;
    pulse_start(32'h0000_1000, 40);
    check("err_low_at_start", err, 1'b0);
    wait_done(1'b1);
    check("slverr_bursts", 64'(aw_count - aw_base), 64'd3);
    check("err_held_after", err, 1'b1);

    // start while busy is ignored; the new start also clears the old error
    aw_base = aw_count;
    plan_job(32'h0000_2000, 48);
    words_to_send += 48;
    pulse_start(32'h0000_2000, 48);
    check("err_cleared", err, 1'b0);
    repeat (10) @(negedge aclk);
    pulse_start(32'h0000_9000, 5);
    wait_done(1'b0);
    repeat (10) @(negedge aclk);
    check("busy_start_ignored", 64'(aw_count - aw_base), 64'd3);
    check("idle_after_ignored", busy, 1'b0);

    // zero-length job
    aw_base = aw_count;
    pulse_start(32'h0000_3000, 0);
    check("zero_irq_next_cycle", finish_irq, 1'b1);
    wait_done(1'b0);
    check("zero_no_aw", 64'(aw_count - aw_base), 64'd0);

    // fill the FIFO while idle, then drain it through an address wrap
    stream_pct = 100;
    words_to_send += 80;
    repeat (90) @(negedge aclk);
    check("fifo_full_tready", bus.tready, 1'b0);
    check("idle_while_filling", busy, 1'b0);
    stream_pct = 50;
    aw_base = aw_count;
    plan_job(32'hFFFF_FFC0, 80);
    pulse_start(32'hFFFF_FFC0, 80);
    wait_done(1'b0);
    check("wrap_bursts", 64'(aw_count - aw_base), 64'd5);

    // reset in the middle of a data burst
    plan_job(32'h0000_4000, 32);
    words_to_send += 32;
    pulse_start(32'h0000_4000, 32);
    t = 0;
    while (!(in_burst && bus.wvalid) && t < 2000) begin
      @(negedge aclk);
      t++;
    end
    check("reached_data", in_burst, 1'b1);
    rdy_en    = 1'b0;
    stream_en = 1'b0;
    @(negedge aclk);
    mon_hold = 1'b1;
    areset   = 1'b1;
    @(negedge aclk);
    check("abort_awvalid", bus.awvalid, 1'b0);
    check("abort_wvalid", bus.wvalid, 1'b0);
    check("abort_bready", bus.bready, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_irq", finish_irq, 1'b0);
    exp_q.delete();
    aw_exp.delete();
    b_plan.delete();
    pending_b     = 0;
    words_to_send = 0;
    in_burst      = 1'b0;
    aw_open       = 1'b0;
    aw_pend       = 1'b0;
    beat_cnt      = 0;
    areset        = 1'b0;
    @(negedge aclk);
    check("tready_after_abort", bus.tready, 1'b1);
    mon_hold  = 1'b0;
    rdy_en    = 1'b1;
    stream_en = 1'b1;

    aw_base = aw_count;
    plan_job(32'h0000_5000, 16);
    words_to_send += 16;
    pulse_start(32'h0000_5000, 16);
    wait_done(1'b0);
    check("post_reset_bursts", 64'(aw_count - aw_base), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_burst_writer.md
AXIS_BURST_WRITER -- requirements
Module: axis_burst_writer

Interface
REQ-001 SHALL have parameter DW, default 32, data width of stream and AXI write channel (multiple of 8).
REQ-002 SHALL have parameter AW, default 32, AXI address width.
REQ-003 SHALL have parameter BURST_LEN, default 16, maximum beats per burst (1..256, BURST_LEN*DW/8 <= 4096).
REQ-004 SHALL have parameter FIFO_DEPTH, default 64, buffer depth in words (power of 2, >= BURST_LEN).
REQ-005 SHALL have parameter IRQ_CYCLES, default 3, finish_irq pulse length.
REQ-006 SHALL have ports, in order:
- aclk  in  1  sole clock, rising edge.
- areset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job start.
- dst_addr  in  AW  job base byte address, sampled on accepted start.
- total_beats  in  32  job length in words, sampled on accepted start.
- s_axis_tdata/tvalid  in  DW/1  input stream.
- s_axis_tready  out  1  stream ready.
- m_axi_awaddr/awlen/awvalid  out  AW/8/1  write address.
- m_axi_awsize/awburst  out  3/2  constant log2(DW/8), INCR.
- m_axi_awready  in  1.
- m_axi_wdata/wstrb/wlast/wvalid  out  DW/DW/8/1/1  write data; wstrb all ones.
- m_axi_wready  in  1.
- m_axi_bresp/bvalid  in  2/1; m_axi_bready  out  1.
- busy  out  1  job in progress.
- err  out  1  sticky non-OKAY response seen in current job.
- finish_irq  out  1  job-complete pulse.

Function
REQ-007 SHALL buffer the stream in a FIFO_DEPTH-word FIFO; s_axis_tready = FIFO not full, independent of state; simultaneous push and pop at full/empty SHALL be handled without loss.
REQ-008 SHALL run FSM IDLE -> ADDR -> DATA -> RESP -> (ADDR | DONE) -> IDLE.
REQ-009 IDLE: start accepted only in IDLE; start while busy SHALL be ignored; total_beats = 0 SHALL go directly to DONE.
REQ-010 Burst beats = min(BURST_LEN, remaining); ADDR SHALL assert awvalid only once the FIFO holds >= beats words, so wvalid never drops mid-burst.
REQ-011 awlen = beats-1; awaddr = base + issued_beats*DW/8; awvalid held until awready, values stable while pending.
REQ-012 DATA: wvalid high each beat until wready; wlast on beat index beats-1 only; data popped only on w handshake.
REQ-013 RESP: bready high; on bvalid, bresp != 0 sets err; then ADDR if remaining > 0, else DONE.
REQ-014 Write address and data SHALL not overlap: one outstanding burst at a time.
REQ-015 DONE: finish_irq high exactly IRQ_CYCLES cycles, then IDLE; busy high from cycle after accepted start through last DONE cycle.
REQ-016 err cleared on accepted start; held after job.
REQ-017 Remaining-beat counter 32-bit; address arithmetic modulo 2^AW (wrap silently).
REQ-018 Stream words arriving while IDLE SHALL be buffered and consumed by the next job; leftover words are not flushed.

Reset
REQ-019 On areset: FSM IDLE, FIFO empty, all valid/ready outputs, busy, err, finish_irq low; awaddr/awlen/wdata zero.
REQ-020 areset mid-burst SHALL abort immediately with no further AXI handshakes; next start begins a fresh job.

Structure
REQ-021 State enum, AXI burst/size/resp constants SHALL live in shared package bicubic_pkg.
REQ-022 The FIFO SHALL be a separate sub-module sync_fifo (DW, FIFO_DEPTH, count output).

Verification
REQ-023 total_beats=40, BURST_LEN=16, dst_addr=0xE0000000, random ready -> bursts awlen 15,15,7 at 0xE0000000, 0xE0000040, 0xE0000080; data in order; wlast on beats 16,32,40.
REQ-024 tvalid random 50%, awready/wready random 50% -> wvalid never deasserts between first beat and wlast of a burst.
REQ-025 bresp=2 on second burst of 3 -> err high from that B through job end, all bursts still issued, finish_irq 3 cycles.
REQ-026 total_beats=0 -> no AW transaction, finish_irq high 3 cycles starting cycle after start.
REQ-027 start pulsed while busy -> ignored, transaction count unchanged.
REQ-028 areset asserted during DATA -> next cycle all valids low, busy low; subsequent job of 16 beats completes correctly.
